// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 keyboard event
//                generator: frame FSM states, special byte values and
//                ps2_key field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Frame receiver states, one per serial field of a device frame
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Prefix bytes that qualify the next scancode
    localparam logic [7:0] c_byte_ext = 8'hE0;
    localparam logic [7:0] c_byte_rel = 8'hF0;

    // Field positions inside the packed ps2_key word
    localparam int TOGGLE  = 10;
    localparam int PRESSED = 9;
    localparam int EXT     = 8;

    // Device responses and error codes that never become key events
    function automatic logic is_drop_byte(input logic [7:0] b);
        logic drop;
        drop = 1'b0;
        case (b)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: drop = 1'b1;
            default:                                          drop = 1'b0;
        endcase
        return drop;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_filter
//  Description : Two-flop synchronizer followed by a run-length filter. The
//                output level flips only after FILTER_LEN consecutive
//                synchronized samples disagree with it. Idles high.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic [7:0] run_q;
    logic [7:0] run_d;

    // Bring the asynchronous pin into the clk_sys domain
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count disagreeing samples; flip the level on the FILTER_LEN-th one
    always_comb begin
        level_d = level_q;
        run_d   = 8'd0;
        if (sync2_q != level_q) begin
            if (run_q == 8'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                run_d   = 8'd0;
            end else begin
                run_d = run_q + 8'd1;
            end
        end
    end

    // Filter state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            level_q <= 1'b1;
            run_q   <= 8'd0;
        end else begin
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_gen
//  Description : Receives device-to-host PS/2 frames and packs accepted
//                scancodes into the 11-bit ps2_key event word
//                {toggle, pressed, extended, code}. Rejected or timed-out
//                frames pulse frame_err for one cycle.
//  Options     : PS2_PARITY_CHECK_EN - when defined, frames with even parity
//                over data+parity are rejected; otherwise parity is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_gen
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int TMO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

    logic             clk_f;
    logic             data_f;
    logic             clk_prev_q;
    logic             fall;
    logic             parity_ok;

    frame_state_t     state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [10:0]      key_q, key_d;
    logic             err_q, err_d;
    logic             ext_q, ext_d;
    logic             rel_q, rel_d;
    logic             accept;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw_i   (ps2_clk),
        .level_o (clk_f)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw_i   (ps2_data),
        .level_o (data_f)
    );

    // Remember the previous filtered clock to detect its falling edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) clk_prev_q <= 1'b1;
        else       clk_prev_q <= clk_f;
    end

    assign fall = clk_prev_q & ~clk_f;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q;

    // Capture the parity bit while the frame is in its parity field
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                              parity_q <= 1'b0;
        else if (fall && state_q == ST_PARITY)  parity_q <= data_f;
    end

    // Odd parity: data plus parity must hold an odd number of ones
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    // Frame sequencing, timeout and byte decode
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        tmo_d    = tmo_q;
        key_d    = key_q;
        err_d    = 1'b0;
        ext_d    = ext_q;
        rel_d    = rel_q;
        accept   = 1'b0;

        if (fall) begin
            // A clock edge always beats a simultaneous timeout
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_f) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_f, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) state_d  = ST_PARITY;
                    else                  bitcnt_d = bitcnt_q + 3'd1;
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_f && parity_ok) accept = 1'b1;
                    else                     err_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        if (err_d) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end

        if (accept) begin
            if (shift_q == c_byte_ext) begin
                ext_d = 1'b1;
            end else if (shift_q == c_byte_rel) begin
                rel_d = 1'b1;
            end else if (is_drop_byte(shift_q)) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else begin
                key_d[TOGGLE]  = ~key_q[TOGGLE];
                key_d[PRESSED] = ~rel_q;
                key_d[EXT]     = ext_q;
                key_d[7:0]     = shift_q;
                ext_d          = 1'b0;
                rel_d          = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= 8'd0;
            bitcnt_q <= 3'd0;
            tmo_q    <= '0;
            key_q    <= 11'h000;
            err_q    <= 1'b0;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            tmo_q    <= tmo_d;
            key_q    <= key_d;
            err_q    <= err_d;
            ext_q    <= ext_d;
            rel_q    <= rel_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_gen
//  Description : Self-checking bench for ps2_key_gen. Drives PS/2 frames
//                (directed and random) and compares ps2_key / frame_err
//                against a byte-level event model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_gen;

    localparam int CLK_HZ     = 25_000_000;
    localparam int TIMEOUT_US = 200;
    localparam int FILTER_LEN = 8;
    localparam int TMO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int HALF       = 40;   // clk_sys cycles per PS/2 clock phase

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_key_gen #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #20 clk_sys = ~clk_sys;   // 25 MHz

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- activity monitors ----------------
    int          cyc = 0;
    int          err_cnt = 0;
    int          evt_cnt = 0;
    int          err_wide = 0;
    int          last_err_cyc = 0;
    int          last_fall_cyc = 0;
    logic        prev_err = 1'b0;
    logic [10:0] prev_key = 11'h000;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (reset) begin
            prev_err = 1'b0;
            prev_key = ps2_key;
        end else begin
            if (frame_err) begin
                err_cnt++;
                last_err_cyc = cyc;
                if (prev_err) err_wide++;
            end
            if (ps2_key !== prev_key) evt_cnt++;
            prev_err = frame_err;
            prev_key = ps2_key;
        end
    end

    // ---------------- reference model ----------------
    logic [10:0] m_key   = 11'h000;
    logic        m_ext   = 1'b0;
    logic        m_rel   = 1'b0;
    int          exp_err = 0;
    int          exp_evt = 0;
    logic [7:0]  drop_list [7] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

    function automatic bit in_drop_list(input logic [7:0] b);
        foreach (drop_list[i]) if (drop_list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_error();
        exp_err++;
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0)            m_ext = 1'b1;
        else if (b == 8'hF0)       m_rel = 1'b1;
        else if (in_drop_list(b)) begin
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            exp_evt++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // One PS/2 bit: data settles while clock is high, device drops clock
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        wait_cycles(HALF / 2);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
        if (glitch) begin
            wait_cycles(5);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(HALF / 2 - 8);
        end else begin
            wait_cycles(HALF / 2);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int glitch_at);
        logic [10:0] bits;
        logic        par;
        par  = (~^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == glitch_at);
        ps2_data = 1'b1;
        if (bad_stop) model_error();
`ifdef PS2_PARITY_CHECK_EN
        else if (bad_par) model_error();
`endif
        else model_byte(b);
        wait_cycles(FILTER_LEN + 8);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".key"}, int'(ps2_key), int'(m_key));
        check_val({tag, ".err"}, err_cnt, exp_err);
        check_val({tag, ".evt"}, evt_cnt, exp_evt);
    endtask

    task automatic model_reset();
        m_key = 11'h000;
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    logic [7:0] special [9] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hEE};

    initial begin
        int e0;
        int t0;
        int diff;
        int exp_lat;
        logic [7:0] b;

        wait_cycles(5);
        check_val("rst.key", int'(ps2_key), 0);
        check_val("rst.err", int'(frame_err), 0);
        reset = 1'b0;
        wait_cycles(20);
        check_state("idle");

        // Plain make code
        send_frame(8'h1C, 0, 0, -1);
        check_state("make_1C");

        // Extended break sequence: only the last byte emits
        send_frame(8'hE0, 0, 0, -1);
        check_state("pre_E0");
        send_frame(8'hF0, 0, 0, -1);
        check_state("pre_F0");
        send_frame(8'h75, 0, 0, -1);
        check_state("brk_E075");
        check_val("brk_E075.low", int'(ps2_key[9:0]), 10'h175);

        // Wrong parity (rejected only when checking is built in)
        send_frame(8'h1C, 1, 0, -1);
        check_state("badpar");

        // Partial frame then silence: timeout
        e0 = err_cnt;
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 0);
        t0 = cyc;
        while (err_cnt == e0 && (cyc - t0) < TMO_CYCLES + 200) wait_cycles(1);
        model_error();
        exp_lat = 2 + FILTER_LEN + 1 + TMO_CYCLES;
        diff    = last_err_cyc - last_fall_cyc;
        check_val("tmo.lat", (diff >= exp_lat - 1 && diff <= exp_lat + 1) ? exp_lat : diff, exp_lat);
        wait_cycles(10);
        check_state("tmo");
        send_frame(8'h29, 0, 0, -1);
        check_state("after_tmo");

        // Responses are swallowed and cancel a pending prefix
        send_frame(8'hAA, 0, 0, -1);
        check_state("drop_AA");
        send_frame(8'hE0, 0, 0, -1);
        send_frame(8'hFA, 0, 0, -1);
        send_frame(8'h1C, 0, 0, -1);
        check_state("drop_FA");
        check_val("drop_FA.ext", int'(ps2_key[8]), 0);

        // Start bit of 1, and a bad stop bit after a prefix
        ps2_bit(1'b1, 0);
        model_error();
        wait_cycles(FILTER_LEN + 8);
        check_state("badstart");
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h33, 0, 1, -1);
        send_frame(8'h34, 0, 0, -1);
        check_state("badstop");

        // Random traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) b = special[$urandom_range(0, 8)];
            else                           b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, -1);
            check_state("rand");
        end

        // Short clock glitch inside a frame is filtered out
        send_frame(8'h4B, 0, 0, 4);
        check_state("glitch");

        // Reset in the middle of a frame
        e0 = evt_cnt;
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 1);
        ps2_bit(1'b0, 0);
        reset = 1'b1;
        wait_cycles(3);
        check_val("midrst.key", int'(ps2_key), 0);
        check_val("midrst.err", int'(frame_err), 0);
        ps2_data = 1'b1;
        reset = 1'b0;
        model_reset();
        wait_cycles(FILTER_LEN + 20);
        check_state("midrst");
        send_frame(8'h1C, 0, 0, -1);
        check_state("post_rst");
        check_val("post_rst.word", int'(ps2_key), 11'h61C);

        check_val("err_width", err_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #(40 * 150_000);
        $display("FAIL watchdog: simulation time limit reached, observed %0d checks, required completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
